// File: rtl/reorder_buffer_if.sv
// ---------------------------------------------------------------------------
// reorder_buffer_if
// Purpose : bundles the dispatch, completion (CDB), retirement and status
//           signals of reorder_buffer into one interface.
// Modports: master - decoder/CDB/free-list side (drives dispatch + CDB)
//           slave  - the reorder buffer itself
// Signals :
//   dispatch_valid/has_dest/dest/dest_old  renamed instruction offered
//   dispatch_ready                         buffer can accept this cycle
//   dispatch_tag                           tag the offered entry will receive
//   cdb_valid/cdb_tag                      completion broadcast
//   return_flag/commit_phys_reg            registered preg return to free list
//   rob_count/rob_empty                    occupancy status
//   flush                                  only when ROB_FLUSH_EN is defined
//
// Handshake: a dispatch transfer happens on a rising clk edge where
// dispatch_valid && dispatch_ready are both 1. dispatch_ready depends only on
// the buffer occupancy, never on dispatch_valid. cdb_valid and return_flag are
// single-cycle pulses with no back-pressure.
// ---------------------------------------------------------------------------
interface reorder_buffer_if #(
    parameter int ROB_DEPTH = 8,
    parameter int PREG_W    = 5
);
    localparam int TAG_W = $clog2(ROB_DEPTH);

    logic              dispatch_valid;
    logic              dispatch_has_dest;
    logic [PREG_W-1:0] dispatch_dest;
    logic [PREG_W-1:0] dispatch_dest_old;
    logic              dispatch_ready;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic              return_flag;
    logic [PREG_W-1:0] commit_phys_reg;
    logic [TAG_W:0]    rob_count;
    logic              rob_empty;
`ifdef ROB_FLUSH_EN
    logic              flush;
`endif

    modport master (
`ifdef ROB_FLUSH_EN
        output flush,
`endif
        output dispatch_valid, dispatch_has_dest, dispatch_dest, dispatch_dest_old,
        output cdb_valid, cdb_tag,
        input  dispatch_ready, dispatch_tag, return_flag, commit_phys_reg,
        input  rob_count, rob_empty
    );

    modport slave (
`ifdef ROB_FLUSH_EN
        input  flush,
`endif
        input  dispatch_valid, dispatch_has_dest, dispatch_dest, dispatch_dest_old,
        input  cdb_valid, cdb_tag,
        output dispatch_ready, dispatch_tag, return_flag, commit_phys_reg,
        output rob_count, rob_empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
// Purpose : in-order retirement buffer behind register renaming. Renamed
//           instructions are allocated at the tail, marked done by the CDB,
//           and retired from the head one per cycle in program order. Each
//           retirement hands the previous mapping (dest_old) back to the
//           rename free list, except preg 0 or entries without a dest.
// Ports   :
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   rob    reorder_buffer_if.slave (dispatch, CDB, retire, status)
// Option  : define ROB_FLUSH_EN to add the rob.flush squash input.
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_DEPTH = 8,
    parameter int PREG_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    reorder_buffer_if.slave rob
);
    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

    // Per-entry storage
    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [ROB_DEPTH-1:0] r_has_dest;
    logic [PREG_W-1:0]    r_dest     [ROB_DEPTH];
    logic [PREG_W-1:0]    r_dest_old [ROB_DEPTH];

    logic [TAG_W-1:0]     r_head;
    logic [TAG_W-1:0]     r_tail;
    logic [TAG_W:0]       r_count;
    logic                 r_return_flag;
    logic [PREG_W-1:0]    r_commit_phys_reg;

    logic                 w_dispatch;
    logic                 w_retire;
    logic                 w_return;
    logic                 w_flush;
    logic                 w_unused_dest;

`ifdef ROB_FLUSH_EN
    assign w_flush = rob.flush;
`else
    assign w_flush = 1'b0;
`endif

    // Ready looks at the registered count only: a full buffer stalls dispatch
    // even on an edge where the head retires.
    assign rob.dispatch_ready  = (r_count != FULL_CNT);
    assign rob.dispatch_tag    = r_tail;
    assign rob.rob_count       = r_count;
    assign rob.rob_empty       = (r_count == '0);
    assign rob.return_flag     = r_return_flag;
    assign rob.commit_phys_reg = r_commit_phys_reg;

    assign w_dispatch = rob.dispatch_valid && (r_count != FULL_CNT);
    // Uses the done bit as it stood before this edge, so a CDB hitting the
    // head on the same edge retires one edge later.
    assign w_retire   = r_valid[r_head] && r_done[r_head];
    // Preg 0 is the hard-wired zero mapping and never goes back to the pool.
    assign w_return   = r_has_dest[r_head] && (r_dest_old[r_head] != '0);

    // The new dest is kept with the entry for debug visibility only; retirement
    // needs just dest_old.
    assign w_unused_dest = ^r_dest[r_head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid           <= '0;
            r_done            <= '0;
            r_has_dest        <= '0;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_return_flag     <= 1'b0;
            r_commit_phys_reg <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_dest[i]     <= '0;
                r_dest_old[i] <= '0;
            end
        end else if (w_flush) begin
            r_valid           <= '0;
            r_done            <= '0;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_return_flag     <= 1'b0;
            r_commit_phys_reg <= '0;
        end else begin
            // Completion first; retire and dispatch below override it on the
            // same entry (later non-blocking assignments win).
            if (rob.cdb_valid && r_valid[rob.cdb_tag]) begin
                r_done[rob.cdb_tag] <= 1'b1;
            end

            if (w_retire) begin
                r_valid[r_head]   <= 1'b0;
                r_done[r_head]    <= 1'b0;
                r_head            <= r_head + TAG_W'(1);
                r_return_flag     <= w_return;
                r_commit_phys_reg <= w_return ? r_dest_old[r_head] : '0;
            end else begin
                r_return_flag     <= 1'b0;
                r_commit_phys_reg <= '0;
            end

            // A CDB naming the slot being allocated loses to the allocation.
            if (w_dispatch) begin
                r_valid[r_tail]    <= 1'b1;
                r_done[r_tail]     <= 1'b0;
                r_has_dest[r_tail] <= rob.dispatch_has_dest;
                r_dest[r_tail]     <= rob.dispatch_dest;
                r_dest_old[r_tail] <= rob.dispatch_dest_old;
                r_tail             <= r_tail + TAG_W'(1);
            end

            case ({w_dispatch, w_retire})
                2'b10:   r_count <= r_count + (TAG_W+1)'(1);
                2'b01:   r_count <= r_count - (TAG_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int ROB_DEPTH = 8;
  localparam int PREG_W    = 5;
  localparam int TAG_W     = $clog2(ROB_DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_DEPTH(ROB_DEPTH), .PREG_W(PREG_W)) rif ();

  reorder_buffer #(.ROB_DEPTH(ROB_DEPTH), .PREG_W(PREG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // In-flight instructions in program order; front is the oldest.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic              has_dest;
    logic [PREG_W-1:0] dest_old;
    logic              done;
  } ent_t;

  ent_t              exp_q[$];
  ent_t              m_ent;
  int                m_tail = 0;
  logic              m_flag = 1'b0;
  logic [PREG_W-1:0] m_commit = '0;
  logic              m_ret;
  logic              m_acc;
  logic              m_flush;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_tail   = 0;
      m_flag   = 1'b0;
      m_commit = '0;
    end else begin
      m_flush = 1'b0;
`ifdef ROB_FLUSH_EN
      m_flush = rif.flush;
`endif
      if (m_flush) begin
        exp_q.delete();
        m_tail   = 0;
        m_flag   = 1'b0;
        m_commit = '0;
      end else begin
        m_ret = (exp_q.size() > 0) && exp_q[0].done;
        m_acc = rif.dispatch_valid && (exp_q.size() < ROB_DEPTH);
        if (rif.cdb_valid)
          foreach (exp_q[i]) if (exp_q[i].tag == rif.cdb_tag) exp_q[i].done = 1'b1;
        if (m_ret) begin
          m_flag   = exp_q[0].has_dest && (exp_q[0].dest_old != 0);
          m_commit = m_flag ? exp_q[0].dest_old : '0;
          void'(exp_q.pop_front());
        end else begin
          m_flag   = 1'b0;
          m_commit = '0;
        end
        if (m_acc) begin
          m_ent.tag      = TAG_W'(m_tail);
          m_ent.has_dest = rif.dispatch_has_dest;
          m_ent.dest_old = rif.dispatch_dest_old;
          m_ent.done     = 1'b0;
          exp_q.push_back(m_ent);
          m_tail = (m_tail + 1) % ROB_DEPTH;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_ready", rif.dispatch_ready, exp_q.size() < ROB_DEPTH);
      check("cmp_tag",   rif.dispatch_tag, m_tail);
      check("cmp_count", rif.rob_count, exp_q.size());
      check("cmp_empty", rif.rob_empty, exp_q.size() == 0);
      check("cmp_flag",  rif.return_flag, m_flag);
      check("cmp_commit", rif.commit_phys_reg, m_commit);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rif.dispatch_valid    = 1'b0;
    rif.dispatch_has_dest = 1'b0;
    rif.dispatch_dest     = '0;
    rif.dispatch_dest_old = '0;
    rif.cdb_valid         = 1'b0;
    rif.cdb_tag           = '0;
`ifdef ROB_FLUSH_EN
    rif.flush             = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic set_disp(input logic hd, input int dest, input int old);
    rif.dispatch_valid    = 1'b1;
    rif.dispatch_has_dest = hd;
    rif.dispatch_dest     = PREG_W'(dest);
    rif.dispatch_dest_old = PREG_W'(old);
  endtask

  task automatic dispatch(input logic hd, input int dest, input int old);
    set_disp(hd, dest, old);
    step();
    rif.dispatch_valid = 1'b0;
  endtask

  task automatic cdb(input int tag);
    rif.cdb_valid = 1'b1;
    rif.cdb_tag   = TAG_W'(tag);
    step();
    rif.cdb_valid = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    cmp_en = 1'b1;
    reset = 1'b0;
    step();

    // 1. reset state
    check("rst_ready", rif.dispatch_ready, 1);
    check("rst_tag",   rif.dispatch_tag, 0);
    check("rst_count", rif.rob_count, 0);
    check("rst_flag",  rif.return_flag, 0);
    check("rst_empty", rif.rob_empty, 1);

    // 2. single dispatch / complete / retire
    dispatch(1'b1, 3, 7);
    check("t2_count1", rif.rob_count, 1);
    cdb(0);
    check("t2_noret", rif.return_flag, 0);
    step();
    check("t2_flag", rif.return_flag, 1);
    check("t2_commit", rif.commit_phys_reg, 7);
    check("t2_count0", rif.rob_count, 0);
    step();
    check("t2_flag_off", rif.return_flag, 0);

    // 3. out-of-order completion, in-order retirement
    do_reset();
    dispatch(1'b1, 20, 10);
    dispatch(1'b1, 21, 11);
    dispatch(1'b1, 22, 12);
    cdb(2);
    check("t3_wait2", rif.return_flag, 0);
    cdb(1);
    check("t3_wait1", rif.return_flag, 0);
    cdb(0);
    check("t3_wait0", rif.return_flag, 0);
    step();
    check("t3_ret0", rif.commit_phys_reg, 10);
    step();
    check("t3_ret1", rif.commit_phys_reg, 11);
    step();
    check("t3_ret2", rif.commit_phys_reg, 12);
    step();
    check("t3_done", rif.rob_count, 0);

    // 4. full buffer, retire with dispatch held, tail wrap
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++) dispatch(1'b1, 16 + i, 1 + i);
    check("t4_full_ready", rif.dispatch_ready, 0);
    check("t4_full_count", rif.rob_count, 8);
    check("t4_full_tag", rif.dispatch_tag, 0);
    set_disp(1'b1, 30, 9);
    cdb(0);
    check("t4_stall_count", rif.rob_count, 8);
    step();
    check("t4_ret_count", rif.rob_count, 7);
    check("t4_ret_commit", rif.commit_phys_reg, 1);
    check("t4_ret_tag", rif.dispatch_tag, 0);
    step();
    rif.dispatch_valid = 1'b0;
    check("t4_wrap_count", rif.rob_count, 8);
    check("t4_wrap_tag", rif.dispatch_tag, 1);

    // 5. no return for dest_old 0 / no dest; stray and repeated CDB
    do_reset();
    dispatch(1'b1, 4, 0);
    dispatch(1'b0, 6, 5);
    cdb(5);
    check("t5_stray", rif.rob_count, 2);
    cdb(0);
    cdb(0);
    check("t5_nozero", rif.return_flag, 0);
    cdb(1);
    check("t5_nodest_count", rif.rob_count, 1);
    step();
    check("t5_nodest_flag", rif.return_flag, 0);
    check("t5_empty", rif.rob_empty, 1);

`ifdef ROB_FLUSH_EN
    // 6a. flush with partially completed contents
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(1'b1, 8 + i, 1 + i);
    cdb(3);
    cdb(4);
    rif.flush = 1'b1;
    set_disp(1'b1, 9, 9);
    step();
    idle();
    check("t6_fl_count", rif.rob_count, 0);
    check("t6_fl_tag", rif.dispatch_tag, 0);
    check("t6_fl_flag", rif.return_flag, 0);
`endif

    // 6b. asynchronous reset in the cycle a retirement is reported
    do_reset();
    dispatch(1'b1, 2, 13);
    cdb(0);
    step();
    check("t6_pre_flag", rif.return_flag, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_ar_flag", rif.return_flag, 0);
    check("t6_ar_commit", rif.commit_phys_reg, 0);
    check("t6_ar_count", rif.rob_count, 0);
    check("t6_ar_ready", rif.dispatch_ready, 1);
    step();
    reset = 1'b0;
    step();
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
